// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-side arbiter.
//   arb_state_e : arbiter FSM states
//   rr_pick_t   : {hit, idx} result of a round-robin search
//   rr_pick()   : loop-based round-robin search from ptr over the low n bits
//                 of req; a readable reference form of what rr_picker builds.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int RR_MAX = 32;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } rr_pick_t;

    // Walk offsets from highest to lowest so the nearest requester after ptr
    // is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input int ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (req[j]) begin
                    r.hit = 1'b1;
                    r.idx = 5'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick.
//   req  in  N      request vector
//   ptr  in  IDX_W  search start index (highest priority)
//   hit  out 1      any request present
//   idx  out IDX_W  first set request at or after ptr, cyclically
// Rotates req so ptr lands at bit 0, priority-encodes the lowest set bit,
// then adds ptr back (mod N) to recover the absolute index.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        int j;
        rot = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            rot[k] = req[IDX_W'(j)];
        end
    end

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
    end

    assign hit = |req;
    assign sum = {1'b0, ptr} + {1'b0, off};
    // Works for non-power-of-two N where the plain IDX_W-bit add would not wrap.
    assign idx = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : sum[IDX_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NUM_REQ producers, with bursts of up to MAX_BURST beats per grant.
//   clk, rst       clock / synchronous active-high reset
//   req, req_data  per-requester valid and packed data (held until ack)
//   ack            one-hot beat accept
//   fifo_full      stalls the current owner (no timeout)
//   fifo_wr_ack    expected one cycle after every fifo_wr_en
//   fifo_overflow  FIFO overflow flag
//   fifo_wr_en, fifo_data_in   FIFO write port
//   owner, busy    current grant holder / grant active
//   err_overflow, err_lost_wr  sticky protocol error flags, cleared by rst
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          err_overflow,
    output logic                          err_lost_wr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             wr_pend;

    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_hit;
    logic             granted;
    logic             rel;

    // Gated by rst so the write port is quiet during the reset cycle itself.
    assign granted      = (state == ARB_GRANT) && !rst;
    assign fifo_wr_en   = granted && req[owner_q] && !fifo_full;
    assign ack          = fifo_wr_en ? (NUM_REQ'(1) << owner_q) : '0;
    assign fifo_data_in = granted ? req_data[owner_q*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign busy         = granted;
    assign owner        = owner_q;

    assign nxt_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // While granted the picker already searches from owner+1, so a release
    // can hand over in the same cycle without an idle bubble.
    assign pick_ptr = (state == ARB_GRANT) ? nxt_ptr : rr_ptr;

    // Stalls on full leave beat_cnt alone; only an accepted last beat or a
    // dropped request ends the grant.
    assign rel = !req[owner_q] || (fifo_wr_en && (beat_cnt == LAST_BEAT));

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            owner_q      <= '0;
            beat_cnt     <= '0;
            wr_pend      <= 1'b0;
            err_overflow <= 1'b0;
            err_lost_wr  <= 1'b0;
        end else begin
            wr_pend <= fifo_wr_en;
            if (wr_pend && !fifo_wr_ack) err_lost_wr  <= 1'b1;
            if (fifo_overflow)           err_overflow <= 1'b1;

            case (state)
                ARB_IDLE: begin
                    if (pick_hit) begin
                        owner_q  <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (fifo_wr_en) beat_cnt <= beat_cnt + 1'b1;
                    if (rel) begin
                        rr_ptr <= nxt_ptr;
                        if (pick_hit) begin
                            owner_q  <= pick_idx;
                            beat_cnt <= '0;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr_ack;
    logic        fifo_overflow;
    logic        fifo_wr_en;
    logic [15:0] fifo_data_in;
    logic [1:0]  owner;
    logic        busy;
    logic        err_overflow;
    logic        err_lost_wr;

    int errors = 0;
    int checks = 0;

    // Behavioural 8-deep FIFO environment with fault-injection hooks.
    logic [3:0]  cnt;
    logic        ovf_q, wr_ack_q;
    logic        rd, drain, preload, force_no_ack, force_ovf;
    logic        m_push, m_pop;
    logic [15:0] wlog[$];

    assign fifo_full     = (cnt == 4'd8);
    assign fifo_wr_ack   = wr_ack_q;
    assign fifo_overflow = ovf_q | force_ovf;
    assign m_push        = fifo_wr_en & ~fifo_full;
    assign m_pop         = (rd | drain) & (cnt != 4'd0);

    always @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            ovf_q    <= 1'b0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= fifo_wr_en & ~force_no_ack;
            ovf_q    <= fifo_wr_en & fifo_full;
            if (preload) cnt <= 4'd7;
            else         cnt <= cnt + {3'd0, m_push} - {3'd0, m_pop};
            if (m_push) wlog.push_back(fifo_data_in);
        end
    end

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .owner(owner), .busy(busy),
        .err_overflow(err_overflow), .err_lost_wr(err_lost_wr)
    );

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req = '0; req_data = '0; rd = 0; drain = 0; preload = 0;
        force_no_ack = 0; force_ovf = 0;
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; req_data = {4{16'hFFFF}};
        rd = 0; drain = 0; preload = 0; force_no_ack = 0; force_ovf = 0;
        @(negedge clk);
        #2;
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL in_reset_wr_en: got %b expected 0", fifo_wr_en); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL in_reset_ack: got %b expected 0000", ack); end
        checks++; if (fifo_data_in !== 16'h0) begin errors++; $display("FAIL in_reset_data: got %h expected 0000", fifo_data_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL in_reset_busy: got %b expected 0", busy); end
        req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({err_overflow, err_lost_wr} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {err_overflow, err_lost_wr}); end
    endtask

    task automatic test_single;
        do_reset;
        req = 4'b0100; req_data[2*16 +: 16] = 16'hA001;
        #2;
        checks++; if (busy !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL single_c0: got busy=%b ack=%b expected 0 0000", busy, ack); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            if (b > 0) req_data[2*16 +: 16] = 16'hA001 + 16'(b);
            #2;
            checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL single_grant%0d: got busy=%b owner=%0d expected 1 2", b, busy, owner); end
            checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack%0d: got %b expected 0100", b, ack); end
            checks++; if (fifo_data_in !== 16'hA001 + 16'(b)) begin errors++; $display("FAIL single_data%0d: got %h expected %h", b, fifo_data_in, 16'hA001 + 16'(b)); end
        end
        @(negedge clk);
        req = 4'b0;
        #2;
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_drop_ack: got %b expected 0000", ack); end
        @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
        checks++; if (wlog.size() !== 3) begin errors++; $display("FAIL single_fifo_count: got %0d expected 3", wlog.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < wlog.size()) begin
                checks++; if (wlog[k] !== 16'hA001 + 16'(k)) begin errors++; $display("FAIL single_fifo_word%0d: got %h expected %h", k, wlog[k], 16'hA001 + 16'(k)); end
            end
        end
        checks++; if (err_lost_wr !== 1'b0) begin errors++; $display("FAIL single_lost_wr: got %b expected 0", err_lost_wr); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_own;
        logic [3:0] exp_ack;
        do_reset;
        drain = 1;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'hB000 + 16'(i);
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #2;
            exp_own = 2'(((c - 1) / 4) % 4);
            exp_ack = 4'b0001 << exp_own;
            checks++; if (ack !== exp_ack || owner !== exp_own || busy !== 1'b1) begin
                errors++; $display("FAIL b2b_c%0d: got ack=%b owner=%0d busy=%b expected %b %0d 1", c, ack, owner, busy, exp_ack, exp_own);
            end
        end
        @(negedge clk);
        req = 4'b0;
        #2;
        checks++; if (wlog.size() !== 20) begin errors++; $display("FAIL b2b_fifo_count: got %0d expected 20", wlog.size()); end
        @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_full_stall;
        do_reset;
        preload = 1;
        @(negedge clk);
        preload = 0;
        req = 4'b0110;
        @(negedge clk);
        #2;
        checks++; if (ack !== 4'b0010 || owner !== 2'd1) begin errors++; $display("FAIL full_first: got ack=%b owner=%0d expected 0010 1", ack, owner); end
        @(negedge clk);
        rd = 1;
        #2;
        checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL full_stall: got wr_en=%b ack=%b expected 0 0000", fifo_wr_en, ack); end
        checks++; if (busy !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL full_hold: got busy=%b owner=%0d expected 1 1", busy, owner); end
        @(negedge clk);
        rd = 0; drain = 1;
        #2;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL full_resume: got %b expected 0010", ack); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL full_beat%0d: got %b expected 0010", c + 3, ack); end
        end
        @(negedge clk);
        #2;
        checks++; if (owner !== 2'd2 || ack !== 4'b0100) begin errors++; $display("FAIL full_rotate: got owner=%0d ack=%b expected 2 0100", owner, ack); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b expected 0", err_overflow); end
        req = 4'b0;
    endtask

    task automatic test_drop;
        do_reset;
        drain = 1;
        req = 4'b1001;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #2;
            checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_beat%0d: got %b expected 0001", c, ack); end
        end
        @(negedge clk);
        req = 4'b1000;
        #2;
        checks++; if (ack !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL drop_release: got ack=%b busy=%b expected 0000 1", ack, busy); end
        @(negedge clk);
        #2;
        checks++; if (owner !== 2'd3 || ack !== 4'b1000) begin errors++; $display("FAIL drop_next: got owner=%0d ack=%b expected 3 1000", owner, ack); end
        req = 4'b0;
        checks++; if (err_lost_wr !== 1'b0) begin errors++; $display("FAIL drop_lost_wr: got %b expected 0", err_lost_wr); end
    endtask

    task automatic test_mid_reset;
        do_reset;
        drain = 1;
        req = 4'b0110;
        @(negedge clk);
        #2;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL mrst_own1: got %b expected 0010", ack); end
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        #2;
        checks++; if (owner !== 2'd2 || ack !== 4'b0100) begin errors++; $display("FAIL mrst_own2: got owner=%0d ack=%b expected 2 0100", owner, ack); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b1111;
        #2;
        checks++; if (ack !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || fifo_data_in !== 16'h0) begin
            errors++; $display("FAIL mrst_during: got ack=%b wr_en=%b busy=%b data=%h expected 0000 0 0 0000", ack, fifo_wr_en, busy, fifo_data_in);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++; if (ack !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_idle: got ack=%b wr_en=%b busy=%b expected 0000 0 0", ack, fifo_wr_en, busy); end
        checks++; if ({err_overflow, err_lost_wr} !== 2'b00) begin errors++; $display("FAIL mrst_flags: got %b expected 00", {err_overflow, err_lost_wr}); end
        @(negedge clk);
        #2;
        checks++; if (owner !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL mrst_ptr0: got owner=%0d ack=%b expected 0 0001", owner, ack); end
        req = 4'b0;
    endtask

    task automatic test_errors;
        do_reset;
        drain = 1;
        req = 4'b0001;
        @(negedge clk);
        force_no_ack = 1;
        #2;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL err_write: got %b expected 0001", ack); end
        @(negedge clk);
        req = 4'b0;
        #2;
        checks++; if (err_lost_wr !== 1'b0) begin errors++; $display("FAIL err_lost_early: got %b expected 0", err_lost_wr); end
        @(negedge clk);
        force_ovf = 1;
        #2;
        checks++; if (err_lost_wr !== 1'b1) begin errors++; $display("FAIL err_lost_set: got %b expected 1", err_lost_wr); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL err_ovf_early: got %b expected 0", err_overflow); end
        @(negedge clk);
        force_ovf = 0;
        #2;
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL err_ovf_set: got %b expected 1", err_overflow); end
        force_no_ack = 0;
        repeat (4) @(negedge clk);
        #2;
        checks++; if ({err_overflow, err_lost_wr} !== 2'b11) begin errors++; $display("FAIL err_sticky: got %b expected 11", {err_overflow, err_lost_wr}); end
        do_reset;
        #2;
        checks++; if ({err_overflow, err_lost_wr} !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b expected 00", {err_overflow, err_lost_wr}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_full_stall;
        test_drop;
        test_mid_reset;
        test_errors;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
